// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for lower-part-OR approximate adders: recomputes A+B,
// accumulates |(A+B)-Y| stats over a window. `APPROX_MON_SQERR_EN adds out_sq_sum.
module approx_err_monitor #(
  parameter int W     = 6,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_err_sum,
  output logic [W:0]       out_err_max,
`ifdef APPROX_MON_SQERR_EN
  output logic [ACC_W-1:0] out_sq_sum,
`endif
  output logic [CNT_W-1:0] out_err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int SUM_EW = ((W + 1) > ACC_W ? (W + 1) : ACC_W) + 1;
  localparam logic [SUM_EW-1:0] SUM_MAX = {{(SUM_EW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] win_q, acc_cnt;
  logic             accept, last_acc, start_ok;

  assign accept   = in_valid & in_ready;
  assign last_acc = accept && ((acc_cnt + CNT_W'(1)) == win_q);
  assign start_ok = (state == IDLE) && start && (window != '0);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN: begin
        in_ready = 1'b1;
        if (last_acc) state_nx = FLUSH;
      end
      FLUSH:   state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      acc_cnt <= '0;
    end else if (start_ok) begin
      win_q   <= window;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Stage 1: exact sum and error distance of the accepted sample.
  logic [W:0] exact, ed_d, ed_q;
  logic       v1, nz_q;

  assign exact = {1'b0, in_a} + {1'b0, in_b};
  assign ed_d  = (exact >= in_y) ? (exact - in_y) : (in_y - exact);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      ed_q <= '0;
      nz_q <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        ed_q <= ed_d;
        nz_q <= (ed_d != '0);
      end
    end
  end

  // Stage 2: saturating accumulation; outputs are the accumulators themselves.
  logic [SUM_EW-1:0] sum_ext;
  assign sum_ext = SUM_EW'(out_err_sum) + SUM_EW'(ed_q);

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      out_err_sum <= '0;
      out_err_max <= '0;
      out_err_cnt <= '0;
    end else if (v1) begin
      out_err_sum <= (sum_ext > SUM_MAX) ? '1 : ACC_W'(sum_ext);
      if (ed_q > out_err_max) out_err_max <= ed_q;
      if (nz_q && (out_err_cnt != '1)) out_err_cnt <= out_err_cnt + CNT_W'(1);
    end
  end

`ifdef APPROX_MON_SQERR_EN
  localparam int P_W   = 2 * (W + 1);
  localparam int SQ_EW = (P_W > ACC_W ? P_W : ACC_W) + 1;
  localparam logic [SQ_EW-1:0] SQ_MAX = {{(SQ_EW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [P_W-1:0]   sq;
  logic [SQ_EW-1:0] sq_ext;
  assign sq     = P_W'(ed_q) * P_W'(ed_q);
  assign sq_ext = SQ_EW'(out_sq_sum) + SQ_EW'(sq);

  always_ff @(posedge clk) begin
    if (rst || start_ok) out_sq_sum <= '0;
    else if (v1)         out_sq_sum <= (sq_ext > SQ_MAX) ? '1 : ACC_W'(sq_ext);
  end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomized bench for approx_err_monitor: a wide-accumulator and a narrow
// (saturating, ACC_W=4) instance share stimulus and are checked against a window model.
module tb_approx_err_monitor;
  localparam int W = 6, CNT_W = 16, ACC_W = 24, ACC_S = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [CNT_W-1:0] window;
  logic [W-1:0] in_a, in_b;
  logic [W:0]   in_y;

  logic busy, in_ready, out_valid;
  logic [ACC_W-1:0] err_sum;
  logic [W:0]       err_max;
  logic [CNT_W-1:0] err_cnt;
  logic s_busy, s_in_ready, s_out_valid;
  logic [ACC_S-1:0] s_err_sum;
  logic [W:0]       s_err_max;
  logic [CNT_W-1:0] s_err_cnt;
`ifdef APPROX_MON_SQERR_EN
  logic [ACC_W-1:0] sq_sum;
  logic [ACC_S-1:0] s_sq_sum;
`endif

  approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_err_sum(err_sum), .out_err_max(err_max),
`ifdef APPROX_MON_SQERR_EN
    .out_sq_sum(sq_sum),
`endif
    .out_err_cnt(err_cnt)
  );

  approx_err_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .window(window), .busy(s_busy),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_err_sum(s_err_sum), .out_err_max(s_err_max),
`ifdef APPROX_MON_SQERR_EN
    .out_sq_sum(s_sq_sum),
`endif
    .out_err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   y;
  } sample_t;

  sample_t     dq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_sum, m_max, m_cnt, m_sq;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] sat_to(input logic [63:0] v, input int bits);
    logic [63:0] mx;
    mx = (64'd1 << bits) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: error distance of one sample folded into plain unbounded totals.
  task automatic model_add(input sample_t s);
    int e;
    e = int'(s.a) + int'(s.b) - int'(s.y);
    if (e < 0) e = -e;
    m_sum += 64'(e);
    m_sq  += 64'(e * e);
    if (64'(e) > m_max) m_max = 64'(e);
    if (e != 0) m_cnt += 64'd1;
  endtask

  task automatic model_clear();
    m_sum = '0; m_max = '0; m_cnt = '0; m_sq = '0;
  endtask

  task automatic check_stats(input string pfx);
    check({pfx, "_sum"},   64'(err_sum),   sat_to(m_sum, ACC_W));
    check({pfx, "_max"},   64'(err_max),   m_max);
    check({pfx, "_cnt"},   64'(err_cnt),   m_cnt);
    check({pfx, "_s_sum"}, 64'(s_err_sum), sat_to(m_sum, ACC_S));
    check({pfx, "_s_max"}, 64'(s_err_max), m_max);
`ifdef APPROX_MON_SQERR_EN
    check({pfx, "_sq"},    64'(sq_sum),    sat_to(m_sq, ACC_W));
    check({pfx, "_s_sq"},  64'(s_sq_sum),  sat_to(m_sq, ACC_S));
`endif
  endtask

  function automatic sample_t rand_sample();
    sample_t s;
    s.a = W'($urandom);
    s.b = W'($urandom);
    if ($urandom_range(0, 1) == 0) s.y = {1'b0, s.a} + {1'b0, s.b};
    else                           s.y = (W + 1)'($urandom);
    return s;
  endfunction

  task automatic drive(input sample_t s);
    in_a = s.a; in_b = s.b; in_y = s.y;
  endtask

  // One full window: queued directed samples first, random ones after.
  task automatic run_window(input int win, input int gap_pct, input int bp, input int start_pct);
    int      acc;
    sample_t s;
    model_clear();
    start = 1'b1; window = CNT_W'(win);
    tick();
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    acc = 0;
    while (acc < win) begin
      if (dq.size() > 0) begin
        s = dq.pop_front();
        in_valid = 1'b1;
      end else begin
        s = rand_sample();
        in_valid = ($urandom_range(0, 99) >= gap_pct);
      end
      drive(s);
      start  = ($urandom_range(0, 99) < start_pct);
      window = CNT_W'($urandom_range(1, 5));
      check("rdy_run",   64'(in_ready),   64'd1);
      check("s_rdy_run", 64'(s_in_ready), 64'd1);
      tick();
      if (in_valid) begin
        model_add(s);
        acc++;
      end
    end
    start = 1'b0;
    in_valid = 1'b1;
    drive(rand_sample());
    check("rdy_flush",   64'(in_ready),  64'd0);
    check("busy_flush",  64'(busy),      64'd1);
    check("valid_flush", 64'(out_valid), 64'd0);
    tick();
    drive(rand_sample());
    check("valid_done",   64'(out_valid),   64'd1);
    check("s_valid_done", 64'(s_out_valid), 64'd1);
    check_stats("done");
    for (int i = 0; i < bp; i++) begin
      tick();
      drive(rand_sample());
      check("valid_hold", 64'(out_valid), 64'd1);
      check_stats("hold");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("busy_idle",  64'(busy),      64'd0);
    check("valid_idle", 64'(out_valid), 64'd0);
    check_stats("idle");
  endtask

  task automatic push(input int a, input int b, input int y);
    sample_t s;
    s.a = W'(a); s.b = W'(b); s.y = (W + 1)'(y);
    dq.push_back(s);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; window = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_y = '0;
    tick(); tick();
    rst = 1'b0;
    model_clear();
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_rdy",   64'(in_ready),  64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check_stats("rst");

    start = 1'b1; window = '0;
    tick();
    start = 1'b0;
    check("win0_busy", 64'(busy), 64'd0);
    check("win0_rdy",  64'(in_ready), 64'd0);
    tick();
    check("win0_busy2", 64'(busy), 64'd0);

    // Directed basic window (err_sum 18, max 16, cnt 3, sq 258), then with backpressure.
    push(3, 1, 3); push(31, 31, 63); push(0, 0, 0); push(16, 16, 48);
    run_window(4, 0, 0, 0);
    check("basic_sum_const", 64'(err_sum), 64'd18);
    push(3, 1, 3); push(31, 31, 63); push(0, 0, 0); push(16, 16, 48);
    run_window(4, 0, 5, 0);

    // Narrow instance saturates at 15 on three distance-16 samples.
    push(16, 16, 48); push(16, 16, 48); push(16, 16, 48);
    run_window(3, 0, 1, 0);
    check("sat_const", 64'(s_err_sum), 64'd15);

    run_window(2, 0, 2, 0);

    // Reset mid-window discards everything.
    model_clear();
    start = 1'b1; window = CNT_W'(4);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive(rand_sample());
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_busy",  64'(busy),      64'd0);
    check("mid_rst_rdy",   64'(in_ready),  64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check_stats("mid_rst");
    run_window(4, 20, 1, 0);

    for (int k = 0; k < 20; k++)
      run_window($urandom_range(1, 12), 30, $urandom_range(0, 3), 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Consumer-side companion to the team's lower-part-OR approximate adders.
- Accepts operand/result samples (A, B, approximate Y) via valid/ready and recomputes the exact sum internally.
- Accumulates error statistics (error-distance sum, maximum error distance, erroneous-sample count) over a programmable window, then presents them on an output handshake.
- Sits downstream of the approximate datapath in characterisation/evaluation builds.

Parameters:
- W, 6, operand width; in_y is W+1 bits.
- CNT_W, 16, width of window and sample counters.
- ACC_W, 24, width of error accumulators.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a measurement window when IDLE.
- window  in  CNT_W  number of samples to measure; sampled on accepted start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor can accept a sample.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_y  in  W+1  approximate-adder result for (in_a, in_b).
- out_valid  out  1  statistics valid.
- out_ready  in  1  downstream accepts statistics.
- out_err_sum  out  ACC_W  sum of |(A+B) - Y|, saturating.
- out_err_max  out  W+1  maximum |(A+B) - Y| in the window.
- out_err_cnt  out  CNT_W  number of samples with Y != A+B.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE; in_ready=0, busy=0, out_valid=0, all out_* = 0, all counters and accumulators = 0. Reset mid-window discards the window without emitting results.
- FSM states:
  - IDLE: in_ready=0. On start=1 with window!=0: latch window, clear accumulators and counters, go to RUN. start with window==0 is ignored and stays in IDLE.
  - RUN: in_ready=1. A sample is accepted on in_valid & in_ready. When the accepted count reaches the latched window, in_ready deasserts the next cycle and the state goes to FLUSH.
  - FLUSH: exactly 1 cycle; the last pipelined sample is accumulated. Then go to DONE.
  - DONE: out_valid=1; out_* are stable and held until out_ready=1. On the handshake cycle, go to IDLE.
- start is ignored outside IDLE.
- out_* keep their last values in IDLE until the next accepted start clears them.
- Datapath is a 2-stage pipeline:
  - Stage 1 (accept cycle): exact = in_a + in_b (W+1 bits); ed = |exact - in_y| (W+1 bits, unsigned); register ed and a flag nz = (ed != 0).
  - Stage 2 (following cycle):
    - err_sum += ed, saturating at 2^ACC_W - 1.
    - err_max = max(err_max, ed).
    - err_cnt += nz, saturating.
- Back-to-back samples: one per cycle in RUN, no bubbles.
- in_valid outside RUN: ignored, no side effects.
- Latency: the last accepted sample produces out_valid exactly 2 cycles later (FLUSH, then DONE).
- The window counter counts accepted samples only. Statistics reflect exactly window samples.

Optional Feature:
- Macro: APPROX_MON_SQERR_EN.
- Defined: adds port out_sq_sum (out, ACC_W), the saturating sum of ed*ed. The stage-2 product is computed in 2*(W+1) bits before accumulation. Its reset, clear and hold rules are identical to out_err_sum.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Basic window: window=4; samples (3,1,Y=3), (31,31,63), (0,0,0), (16,16,48), one per cycle; out_ready=1 → out_err_sum=18, out_err_max=16, out_err_cnt=3; out_valid rises 2 cycles after the 4th accept. With APPROX_MON_SQERR_EN, out_sq_sum=258.
- Backpressure: same window with out_ready=0 for 5 cycles → out_* stable and out_valid held for 5 cycles; IDLE entered the cycle after out_ready=1.
- Window boundary: window=2; in_valid held high for 4 cycles → exactly 2 samples accepted; in_ready=0 from the 3rd cycle; err_cnt counts only those 2 samples.
- Ignored controls: start with window=0 → busy stays 0. start pulsed during RUN → no restart, counts continue.
- Saturation: ACC_W=4, window=3, three samples (16,16,48) → out_err_sum=15 (saturated), out_err_max=16.
- Reset mid-window: rst after 2 of 4 samples → next cycle busy=0, in_ready=0, out_*=0. A new start then measures a fresh window correctly.
